// File: rtl/uart_xfifo.sv
// Parametrised single-clock FIFO for the UART TX/RX data paths: show-ahead read,
// registered occupancy flags, sticky overflow/underflow and a synchronous flush.
module uart_xfifo #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_err,
  input  logic              wr,
  input  logic [DWIDTH-1:0] w_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic              we;
  logic              re;
  logic              ovf_evt;
  logic              unf_evt;
  logic [AWIDTH:0]   count_next;

  // Flush discards both requests in its cycle, so neither can raise an error.
  assign we      = wr & ~full  & ~flush;
  assign re      = rd & ~empty & ~flush;
  assign ovf_evt = wr & full  & ~flush;
  assign unf_evt = rd & empty & ~flush;

  always_comb begin
    count_next = count;
    if (flush) count_next = '0;
    else       count_next = count + {{AWIDTH{1'b0}}, we} - {{AWIDTH{1'b0}}, re};
  end

  // NOTE: the storage array has no reset; its contents are only observable once
  // a write has made the FIFO non-empty, and leaving it out lets it map to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= w_data;
  end

  assign r_data = mem[rptr];

  // NOTE: every register here uses <= so all of them see the same pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (we) wptr <= wptr + 1'b1;
        if (re) rptr <= rptr + 1'b1;
      end
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == (AWIDTH+1)'(DEPTH));
      almost_empty <= (count_next <= (AWIDTH+1)'(AE_LEVEL));
      almost_full  <= (count_next >= (AWIDTH+1)'(AF_LEVEL));
      // A new error event in the same cycle as clr_err leaves the flag set.
      overflow     <= (overflow  & ~clr_err) | ovf_evt;
      underflow    <= (underflow & ~clr_err) | unf_evt;
    end
  end

endmodule
